// File: rtl/memory_stage.sv
// MEM stage: takes one EXE bundle per handshake, runs the data-SRAM access, aligns load
// data, builds store strobes, and holds the result in the pipeline register read by WB.
module memory_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_en,
    input  logic [REG_AW-1:0] in_reg_waddr,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [1:0]        in_mem_size,
    input  logic              in_mem_sign,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic              in_double_en,
    input  logic              in_MD_result,
    output logic              data_req,
    output logic              data_wr,
    output logic [DATA_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_rvalid,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              exe_reg_en,
    output logic [REG_AW-1:0] exe_reg_waddr,
    output logic              exe_mem_read,
    output logic [DATA_W-1:0] alu_result_reg,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              exe_double_en,
    output logic              exe_MD_result,
    output logic              addr_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              is_mem;
    logic              misalign;
    logic              go_req;
    logic [1:0]        in_lane;
    logic [3:0]        strb_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              wr_q;
    logic [3:0]        strb_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [DATA_W-1:0] load_val;
    logic [1:0]        ld_lane;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    assign in_lane = in_alu_result[1:0];

    // Decode of the incoming bundle, used only on the accept edge.
    always_comb begin
        is_mem    = in_mem_read | in_mem_write;
        misalign  = 1'b0;
        strb_nxt  = 4'b1111;
        wdata_nxt = in_store_data;
        case (in_mem_size)
            2'd0: begin
                strb_nxt  = 4'b0001 << in_lane;
                wdata_nxt = {4{in_store_data[7:0]}};
            end
            2'd1: begin
                misalign  = is_mem & in_lane[0];
                strb_nxt  = 4'b0011 << in_lane;
                wdata_nxt = {2{in_store_data[15:0]}};
            end
            default: misalign = is_mem & (in_lane != 2'b00);
        endcase
        go_req = is_mem & ~misalign;
    end

    // Load alignment from the latched address and size.
    always_comb begin
        ld_lane  = alu_result_reg[1:0];
        ld_byte  = data_rdata[{ld_lane, 3'b000} +: 8];
        ld_half  = data_rdata[{ld_lane[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    load_val = {{(DATA_W-8){sign_q & ld_byte[7]}}, ld_byte};
            2'd1:    load_val = {{(DATA_W-16){sign_q & ld_half[15]}}, ld_half};
            default: load_val = data_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        data_req  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = go_req ? REQ : FULL;
            end
            REQ: begin
                data_req = 1'b1;
                if (data_addr_ok) state_nxt = WAIT;
            end
            WAIT: if (data_rvalid) state_nxt = FULL;
            FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? (go_req ? REQ : FULL) : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept     = in_valid & in_ready;
    assign data_addr  = {alu_result_reg[DATA_W-1:2], 2'b00};
    // Write-side signals only carry meaning while the request is outstanding.
    assign data_wr    = data_req & wr_q;
    assign data_wstrb = data_wr ? strb_q : 4'b0000;
    assign data_wdata = data_wr ? wdata_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            exe_reg_en     <= 1'b0;
            exe_reg_waddr  <= '0;
            exe_mem_read   <= 1'b0;
            alu_result_reg <= '0;
            mem_rdata      <= '0;
            exe_double_en  <= 1'b0;
            exe_MD_result  <= 1'b0;
            addr_err       <= 1'b0;
            wr_q           <= 1'b0;
            strb_q         <= 4'b0000;
            wdata_q        <= '0;
            size_q         <= 2'd0;
            sign_q         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                exe_reg_en     <= in_reg_en & ~misalign;
                exe_reg_waddr  <= in_reg_waddr;
                exe_mem_read   <= in_mem_read;
                alu_result_reg <= in_alu_result;
                mem_rdata      <= '0;
                exe_double_en  <= in_double_en;
                exe_MD_result  <= in_MD_result;
                addr_err       <= misalign;
                // A load takes priority when both read and write are flagged.
                wr_q           <= in_mem_write & ~in_mem_read;
                strb_q         <= strb_nxt;
                wdata_q        <= wdata_nxt;
                size_q         <= in_mem_size;
                sign_q         <= in_mem_sign;
            end else if (state == WAIT && data_rvalid && exe_mem_read) begin
                mem_rdata <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized transactions
// checked against a byte-level reference model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_reg_en, in_mem_read, in_mem_write, in_mem_sign;
    logic [5:0]  in_reg_waddr;
    logic [1:0]  in_mem_size;
    logic [31:0] in_alu_result, in_store_data;
    logic        in_double_en, in_MD_result;
    logic        data_req, data_wr, data_addr_ok, data_rvalid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        out_valid, out_ready;
    logic        exe_reg_en, exe_mem_read, exe_double_en, exe_MD_result, addr_err;
    logic [5:0]  exe_reg_waddr;
    logic [31:0] alu_result_reg, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_stage #(.DATA_W(32), .REG_AW(6)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_en(in_reg_en), .in_reg_waddr(in_reg_waddr),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_size(in_mem_size), .in_mem_sign(in_mem_sign),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_double_en(in_double_en), .in_MD_result(in_MD_result),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .exe_reg_en(exe_reg_en), .exe_reg_waddr(exe_reg_waddr),
        .exe_mem_read(exe_mem_read), .alu_result_reg(alu_result_reg),
        .mem_rdata(mem_rdata), .exe_double_en(exe_double_en),
        .exe_MD_result(exe_MD_result), .addr_err(addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes, byte-wise strobes and replication.
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] size,
                                           input logic sgn, input logic [31:0] rd);
        int n = nbytes(size);
        logic [31:0] mask, v;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v = (rd >> (8 * int'(a[1:0]))) & mask;
        if (sgn && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input logic [31:0] a, input logic [1:0] size);
        int n = nbytes(size);
        logic [3:0] s = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= int'(a[1:0]) && i < int'(a[1:0]) + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] sd, input logic [1:0] size);
        int n = nbytes(size);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    task automatic drive(input logic reg_en, input logic [5:0] wa, input logic rd, input logic wr,
                         input logic [1:0] size, input logic sgn, input logic [31:0] alu,
                         input logic [31:0] sd, input logic dbl, input logic md);
        in_reg_en = reg_en; in_reg_waddr = wa; in_mem_read = rd; in_mem_write = wr;
        in_mem_size = size; in_mem_sign = sgn; in_alu_result = alu; in_store_data = sd;
        in_double_en = dbl; in_MD_result = md;
    endtask

    // One full transaction from IDLE back to IDLE, with every cycle checked against the model.
    task automatic run_txn(input logic reg_en, input logic [5:0] wa, input logic rd, input logic wr,
                           input logic [1:0] size, input logic sgn, input logic [31:0] alu,
                           input logic [31:0] sd, input logic [31:0] rdat,
                           input int okd, input int rvd, input int hold,
                           input logic dbl, input logic md);
        int   n   = nbytes(size);
        logic mem = rd | wr;
        logic mis = mem && ((int'(alu[1:0]) % n) != 0);
        logic st  = wr & ~rd;
        logic [31:0] exp_rd = (rd && !mis) ? m_load(alu, size, sgn, rdat) : 32'd0;
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        drive(reg_en, wa, rd, wr, size, sgn, alu, sd, dbl, md);
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_alu_result = $urandom; in_store_data = $urandom;
        if (mem && !mis) begin
            chk("req", {31'd0, data_req}, 32'd1);
            chk("req_addr", data_addr, {alu[31:2], 2'b00});
            chk("req_wr", {31'd0, data_wr}, {31'd0, st});
            chk("req_strb", {28'd0, data_wstrb}, st ? {28'd0, m_strb(alu, size)} : 32'd0);
            if (st) chk("req_wdata", data_wdata, m_wdata(sd, size));
            chk("req_in_ready", {31'd0, in_ready}, 32'd0);
            data_rvalid = 1'b1; data_rdata = $urandom;
            repeat (okd) begin
                @(negedge clk);
                chk("req_hold", {31'd0, data_req}, 32'd1);
                chk("req_hold_addr", data_addr, {alu[31:2], 2'b00});
            end
            data_rvalid = 1'b0;
            data_addr_ok = 1'b1;
            @(negedge clk);
            data_addr_ok = 1'b0;
            chk("wait_noreq", {31'd0, data_req}, 32'd0);
            chk("wait_nov", {31'd0, out_valid}, 32'd0);
            repeat (rvd) begin
                @(negedge clk);
                chk("wait_nov2", {31'd0, out_valid}, 32'd0);
            end
            data_rvalid = 1'b1; data_rdata = rdat;
            @(negedge clk);
            data_rvalid = 1'b0;
        end else begin
            chk("no_req", {31'd0, data_req}, 32'd0);
        end
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("reg_en", {31'd0, exe_reg_en}, {31'd0, reg_en & ~mis});
        chk("waddr", {26'd0, exe_reg_waddr}, {26'd0, wa});
        chk("alu", alu_result_reg, alu);
        chk("mem_rdata", mem_rdata, exp_rd);
        chk("addr_err", {31'd0, addr_err}, {31'd0, mis});
        chk("mem_read", {31'd0, exe_mem_read}, {31'd0, rd});
        chk("dbl_md", {30'd0, exe_double_en, exe_MD_result}, {30'd0, dbl, md});
        // Stray handshakes while full must be ignored.
        data_rvalid = 1'b1; data_addr_ok = 1'b1; data_rdata = $urandom;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_rdata", mem_rdata, exp_rd);
            chk("hold_noreq", {31'd0, data_req}, 32'd0);
        end
        data_rvalid = 1'b0; data_addr_ok = 1'b0;
        out_ready = 1'b1;
        #1 chk("full_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("drained", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        data_addr_ok = 1'b0; data_rvalid = 1'b0; data_rdata = 32'd0;
        drive(1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_outs", {25'd0, out_valid, data_req, data_wr, exe_reg_en, exe_mem_read,
                         addr_err, exe_double_en}, 32'd0);
        chk("rst_alu", alu_result_reg, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_addr", data_addr, 32'd0);

        // ALU op, LB/LBU, SH, misaligned LW, read-wins-over-write
        run_txn(1'b1, 6'd5, 1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'd0, 32'd0, 0, 0, 0, 1'b0, 1'b0);
        run_txn(1'b1, 6'd7, 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 32'h80FF0000, 0, 0, 0, 1'b0, 1'b0);
        chk("lb_value", mem_rdata, 32'hFFFF_FF80);
        run_txn(1'b1, 6'd7, 1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 32'h80FF0000, 1, 1, 1, 1'b0, 1'b0);
        chk("lbu_value", mem_rdata, 32'h0000_0080);
        run_txn(1'b0, 6'd0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 32'd0, 2, 0, 0, 1'b0, 1'b0);
        run_txn(1'b1, 6'd9, 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 32'd0, 0, 0, 1, 1'b0, 1'b0);
        run_txn(1'b1, 6'd3, 1'b1, 1'b1, 2'd1, 1'b1, 32'h206, 32'h1111, 32'h8001_7FFF, 0, 2, 0, 1'b1, 1'b1);

        // Back-pressure then back-to-back accept with no bubble
        @(negedge clk);
        drive(1'b1, 6'd1, 1'b0, 1'b0, 2'd2, 1'b0, 32'hAAAA, 32'd0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_alu", alu_result_reg, 32'hAAAA);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        drive(1'b1, 6'd2, 1'b0, 1'b0, 2'd2, 1'b0, 32'hBBBB, 32'd0, 1'b0, 1'b1);
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_alu", alu_result_reg, 32'hBBBB);
        chk("b2b_waddr", {26'd0, exe_reg_waddr}, 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_drain", {31'd0, out_valid}, 32'd0);

        // Reset while waiting for read data; the late response must be ignored
        @(negedge clk);
        drive(1'b1, 6'd4, 1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk("rw_wait", {30'd0, data_req, out_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        data_rvalid = 1'b1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        data_rvalid = 1'b0;
        chk("rw_nov", {31'd0, out_valid}, 32'd0);
        chk("rw_rdy", {31'd0, in_ready}, 32'd1);
        chk("rw_noreq", {31'd0, data_req}, 32'd0);
        chk("rw_rdata", mem_rdata, 32'd0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            int op = $urandom_range(0, 3);
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_txn(1'($urandom), 6'($urandom), op[0], op[1], 2'($urandom), 1'($urandom),
                    a, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
